axi_rd_fsm_0: RTL and testbench

AXI4 read-slave control FSM. It is the read-side counterpart of the write FSM that pushes into the varint and raw-data input FIFOs. It accepts AR requests, pops words from the varint-output or raw-data-output FIFO (both show-ahead), and returns them on the R channel with registered rdata, rid, rresp and rlast. It sits between the AXI4 interconnect and the encoder output FIFOs.

---
 rtl/axi_fsm_pkg.sv | 36 +++
 rtl/axi_rd_fsm_0_if.sv | 43 ++++
 rtl/axi_rd_fsm_0.sv | 143 ++++++++++++++
 tb/tb_axi_rd_fsm_0.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_fsm_pkg.sv
// Shared definitions for the AXI4 encoder-side FSMs: state and target encodings,
// response codes and the register-map addresses used by both read and write sides.
package axi_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    FETCH  = 3'b010,
    RVALID = 3'b100
  } rd_state_t;

  typedef enum logic [1:0] {
    VARINT = 2'd0,
    RAW    = 2'd1,
    STATUS = 2'd2,
    ERR    = 2'd3
  } target_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] VARINT_ADDR_DEF = 8'h00;
  localparam logic [7:0] RAW_ADDR_DEF    = 8'hF0;
  localparam logic [7:0] STATUS_ADDR_DEF = 8'h80;

  // Only the low address byte selects a port; anything unmapped answers SLVERR.
  function automatic target_t decode_target(input logic [7:0] addr,
                                            input logic [7:0] varint_addr,
                                            input logic [7:0] raw_addr,
                                            input logic [7:0] status_addr);
    if (addr == varint_addr)      return VARINT;
    else if (addr == raw_addr)    return RAW;
    else if (addr == status_addr) return STATUS;
    else                          return ERR;
  endfunction

endpackage

// File: rtl/axi_rd_fsm_0_if.sv
// AR/R channel of the AXI4 read slave plus the two show-ahead output FIFO ports.
interface axi_rd_fsm_0_if #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]   axs_s0_arid;
  logic [31:0]       axs_s0_araddr;
  logic [7:0]        axs_s0_arlen;
  logic [2:0]        axs_s0_arsize;
  logic [1:0]        axs_s0_arburst;
  logic              axs_s0_arvalid;
  logic              axs_s0_arready;
  logic [ID_W-1:0]   axs_s0_rid;
  logic [DATA_W-1:0] axs_s0_rdata;
  logic [1:0]        axs_s0_rresp;
  logic              axs_s0_rlast;
  logic              axs_s0_rvalid;
  logic              axs_s0_rready;
  logic              varint_out_fifo_empty;
  logic [DATA_W-1:0] varint_out_fifo_data;
  logic              varint_out_fifo_pop;
  logic              raw_data_out_fifo_empty;
  logic [DATA_W-1:0] raw_data_out_fifo_data;
  logic              raw_data_out_fifo_pop;

  modport slave (
    input  axs_s0_arid, axs_s0_araddr, axs_s0_arlen, axs_s0_arsize, axs_s0_arburst,
           axs_s0_arvalid, axs_s0_rready,
           varint_out_fifo_empty, varint_out_fifo_data,
           raw_data_out_fifo_empty, raw_data_out_fifo_data,
    output axs_s0_arready, axs_s0_rid, axs_s0_rdata, axs_s0_rresp, axs_s0_rlast,
           axs_s0_rvalid, varint_out_fifo_pop, raw_data_out_fifo_pop
  );

  modport master (
    output axs_s0_arid, axs_s0_araddr, axs_s0_arlen, axs_s0_arsize, axs_s0_arburst,
           axs_s0_arvalid, axs_s0_rready,
           varint_out_fifo_empty, varint_out_fifo_data,
           raw_data_out_fifo_empty, raw_data_out_fifo_data,
    input  axs_s0_arready, axs_s0_rid, axs_s0_rdata, axs_s0_rresp, axs_s0_rlast,
           axs_s0_rvalid, varint_out_fifo_pop, raw_data_out_fifo_pop
  );
endinterface

// File: rtl/axi_rd_fsm_0.sv
// AXI4 read-slave FSM: one burst at a time, each beat popped from the selected
// show-ahead FIFO (or the status word / SLVERR) and returned on a registered R channel.
module axi_rd_fsm_0
  import axi_fsm_pkg::*;
#(
  parameter int         ID_W        = 4,
  parameter int         DATA_W      = 32,
  parameter logic [7:0] VARINT_ADDR = VARINT_ADDR_DEF,
  parameter logic [7:0] RAW_ADDR    = RAW_ADDR_DEF,
  parameter logic [7:0] STATUS_ADDR = STATUS_ADDR_DEF
) (
  input logic           clk,
  input logic           reset,
  axi_rd_fsm_0_if.slave bus
);

  rd_state_t         state_reg, state_next;
  target_t           target_reg, target_next;
  logic [7:0]        beat_cnt_reg, beat_cnt_next;
  logic [ID_W-1:0]   rid_reg, rid_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [1:0]        rresp_reg, rresp_next;
  logic              rlast_reg, rlast_next;
  logic              rvalid_reg, rvalid_next;
  logic              arready_reg, arready_next;

  logic              sel_empty;
  logic [DATA_W-1:0] sel_data;
  logic              unused_ar_fields;

  assign unused_ar_fields = ^{bus.axs_s0_arsize, bus.axs_s0_arburst, bus.axs_s0_araddr[31:8]};

  assign sel_empty = (target_reg == RAW) ? bus.raw_data_out_fifo_empty : bus.varint_out_fifo_empty;
  assign sel_data  = (target_reg == RAW) ? bus.raw_data_out_fifo_data  : bus.varint_out_fifo_data;

  // Pops are the only unregistered outputs: one per FETCH cycle that finds data.
  assign bus.varint_out_fifo_pop   = (state_reg == FETCH) && (target_reg == VARINT) && !bus.varint_out_fifo_empty;
  assign bus.raw_data_out_fifo_pop = (state_reg == FETCH) && (target_reg == RAW) && !bus.raw_data_out_fifo_empty;

  always_comb begin
    state_next    = state_reg;
    target_next   = target_reg;
    beat_cnt_next = beat_cnt_reg;
    rid_next      = rid_reg;
    rdata_next    = rdata_reg;
    rresp_next    = rresp_reg;
    rlast_next    = rlast_reg;
    rvalid_next   = rvalid_reg;
    arready_next  = arready_reg;
    case (state_reg)
      IDLE: begin
        arready_next = 1'b1;
        if (bus.axs_s0_arvalid && arready_reg) begin
          rid_next      = bus.axs_s0_arid;
          target_next   = decode_target(bus.axs_s0_araddr[7:0], VARINT_ADDR, RAW_ADDR, STATUS_ADDR);
          beat_cnt_next = bus.axs_s0_arlen;
          arready_next  = 1'b0;
          state_next    = FETCH;
        end
      end
      FETCH: begin
        arready_next = 1'b0;
        rvalid_next  = 1'b0;
        case (target_reg)
          VARINT, RAW: begin
            if (!sel_empty) begin
              rdata_next  = sel_data;
              rresp_next  = RESP_OKAY;
              rlast_next  = (beat_cnt_reg == 8'd0);
              rvalid_next = 1'b1;
              state_next  = RVALID;
            end
          end
          STATUS: begin
            rdata_next      = '0;
            rdata_next[1:0] = {bus.raw_data_out_fifo_empty, bus.varint_out_fifo_empty};
            rresp_next      = RESP_OKAY;
            rlast_next      = (beat_cnt_reg == 8'd0);
            rvalid_next     = 1'b1;
            state_next      = RVALID;
          end
          default: begin
            rdata_next  = '0;
            rresp_next  = RESP_SLVERR;
            rlast_next  = (beat_cnt_reg == 8'd0);
            rvalid_next = 1'b1;
            state_next  = RVALID;
          end
        endcase
      end
      RVALID: begin
        if (bus.axs_s0_rready) begin
          rvalid_next = 1'b0;
          if (rlast_reg) begin
            rlast_next   = 1'b0;
            arready_next = 1'b1;
            state_next   = IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg - 8'd1;
            state_next    = FETCH;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        arready_next = 1'b0;
        rvalid_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      target_reg   <= VARINT;
      beat_cnt_reg <= '0;
      rid_reg      <= '0;
      rdata_reg    <= '0;
      rresp_reg    <= '0;
      rlast_reg    <= 1'b0;
      rvalid_reg   <= 1'b0;
      arready_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      target_reg   <= target_next;
      beat_cnt_reg <= beat_cnt_next;
      rid_reg      <= rid_next;
      rdata_reg    <= rdata_next;
      rresp_reg    <= rresp_next;
      rlast_reg    <= rlast_next;
      rvalid_reg   <= rvalid_next;
      arready_reg  <= arready_next;
    end
  end

  assign bus.axs_s0_arready = arready_reg;
  assign bus.axs_s0_rid     = rid_reg;
  assign bus.axs_s0_rdata   = rdata_reg;
  assign bus.axs_s0_rresp   = rresp_reg;
  assign bus.axs_s0_rlast   = rlast_reg;
  assign bus.axs_s0_rvalid  = rvalid_reg;

endmodule

// File: tb/tb_axi_rd_fsm_0.sv
// Randomized bench for axi_rd_fsm_0: emulated show-ahead FIFOs, per-port expected
// word streams and a beat scoreboard derived from the burst rules.
`timescale 1ns/1ps
module tb_axi_rd_fsm_0;
  localparam int ID_W = 4;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_rd_fsm_0_if #(.ID_W(ID_W), .DATA_W(DATA_W)) bus ();
  axi_rd_fsm_0 #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: FIFO storage, pending pushes, expected per-port word streams.
  logic [31:0] v_fifo[$], r_fifo[$], v_push[$], r_push[$], v_exp[$], r_exp[$];
  int          pop_cnt = 0;
  int          cur_tgt = 0;          // 0 varint, 1 raw, 2 status, 3 error
  logic        burst_active = 1'b0;
  logic        burst_done = 1'b0;
  int          exp_len = 0;
  int          beat_idx = 0;
  logic [3:0]  exp_id = '0;
  logic [31:0] exp_status = '0;
  int          rready_pct = 100;
  logic        rready_low = 1'b0;

  task automatic push_word(input int tgt, input logic [31:0] w);
    if (tgt == 0) begin v_push.push_back(w); v_exp.push_back(w); end
    else          begin r_push.push_back(w); r_exp.push_back(w); end
  endtask

  // Emulated show-ahead FIFOs: pops observed mid-cycle take effect at the next edge.
  initial begin
    logic vp, rp;
    bus.varint_out_fifo_empty = 1'b1; bus.varint_out_fifo_data = '0;
    bus.raw_data_out_fifo_empty = 1'b1; bus.raw_data_out_fifo_data = '0;
    forever begin
      @(negedge clk);
      vp = bus.varint_out_fifo_pop;
      rp = bus.raw_data_out_fifo_pop;
      if (vp) begin
        check_val("pop_v_nonempty", v_fifo.size() != 0, 1);
        check_val("pop_v_selected", burst_active && cur_tgt == 0, 1);
        pop_cnt++;
      end
      if (rp) begin
        check_val("pop_r_nonempty", r_fifo.size() != 0, 1);
        check_val("pop_r_selected", burst_active && cur_tgt == 1, 1);
        pop_cnt++;
      end
      @(posedge clk); #1;
      if (vp && v_fifo.size() > 0) void'(v_fifo.pop_front());
      if (rp && r_fifo.size() > 0) void'(r_fifo.pop_front());
      while (v_push.size() > 0) v_fifo.push_back(v_push.pop_front());
      while (r_push.size() > 0) r_fifo.push_back(r_push.pop_front());
      bus.varint_out_fifo_empty   = (v_fifo.size() == 0);
      bus.varint_out_fifo_data    = (v_fifo.size() != 0) ? v_fifo[0] : 32'h0;
      bus.raw_data_out_fifo_empty = (r_fifo.size() == 0);
      bus.raw_data_out_fifo_data  = (r_fifo.size() != 0) ? r_fifo[0] : 32'h0;
    end
  end

  initial begin
    bus.axs_s0_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.axs_s0_rready = !rready_low && ($urandom_range(0, 99) < rready_pct);
    end
  end

  // Beat scoreboard: one line per accepted beat, plus hold-stability while stalled.
  initial begin
    logic [31:0] hd, ed;
    logic        hl, hv;
    logic [1:0]  hr;
    hv = 1'b0; hd = '0; hl = 1'b0; hr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin hv = 1'b0; continue; end
      if (burst_active) check_val("arready_busy", bus.axs_s0_arready, 0);
      if (hv) begin
        check_val("hold_rvalid", bus.axs_s0_rvalid, 1);
        check_val("hold_rdata", bus.axs_s0_rdata, hd);
        check_val("hold_rlast", bus.axs_s0_rlast, hl);
        check_val("hold_rresp", bus.axs_s0_rresp, hr);
      end
      hv = bus.axs_s0_rvalid && !bus.axs_s0_rready;
      hd = bus.axs_s0_rdata; hl = bus.axs_s0_rlast; hr = bus.axs_s0_rresp;
      if (bus.axs_s0_rvalid && bus.axs_s0_rready) begin
        if (!burst_active) check_val("rvalid_idle", bus.axs_s0_rvalid, 0);
        else begin
          case (cur_tgt)
            0: ed = (v_exp.size() != 0) ? v_exp.pop_front() : 32'hBAD0_0000;
            1: ed = (r_exp.size() != 0) ? r_exp.pop_front() : 32'hBAD0_0001;
            2: ed = exp_status;
            default: ed = 32'h0;
          endcase
          $display("beat tgt=%0d idx=%0d id=%0h data=%08h resp=%0d last=%0b", cur_tgt, beat_idx,
                   bus.axs_s0_rid, bus.axs_s0_rdata, bus.axs_s0_rresp, bus.axs_s0_rlast);
          check_val("rdata", bus.axs_s0_rdata, ed);
          check_val("rresp", bus.axs_s0_rresp, (cur_tgt == 3) ? 2'b10 : 2'b00);
          check_val("rid", bus.axs_s0_rid, exp_id);
          check_val("rlast", bus.axs_s0_rlast, beat_idx == exp_len);
          beat_idx++;
          if (beat_idx > exp_len) begin burst_active = 1'b0; burst_done = 1'b1; end
        end
      end
    end
  end

  task automatic issue_ar(input logic [7:0] addr, input int len, input logic [3:0] id,
                          input int tgt, input bit check_lat);
    int t;
    @(posedge clk); #1;
    bus.axs_s0_arvalid = 1'b1;
    bus.axs_s0_araddr  = {$urandom_range(0, 32'h00FF_FFFF), 8'h00} | {24'h0, addr};
    bus.axs_s0_arlen   = 8'(len);
    bus.axs_s0_arid    = id;
    bus.axs_s0_arsize  = 3'($urandom_range(0, 7));
    bus.axs_s0_arburst = 2'($urandom_range(0, 3));
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.axs_s0_arready && t < 50);
    check_val("ar_accept", bus.axs_s0_arready, 1);
    cur_tgt = tgt; exp_len = len; exp_id = id; beat_idx = 0; pop_cnt = 0; burst_done = 1'b0;
    exp_status = {30'h0, r_fifo.size() == 0, v_fifo.size() == 0};
    @(posedge clk); #1;
    bus.axs_s0_arvalid = 1'b0;
    burst_active = 1'b1;
    if (check_lat) begin
      @(negedge clk); check_val("lat_fetch_rvalid", bus.axs_s0_rvalid, 0);
      @(negedge clk); check_val("lat_beat_rvalid", bus.axs_s0_rvalid, 1);
    end
  endtask

  task automatic wait_done(input int tgt, input int len);
    int t;
    t = 0;
    while (!burst_done && t < 3000) begin @(negedge clk); t++; end
    check_val("burst_done", burst_done, 1);
    check_val("pop_count", pop_cnt, (tgt < 2) ? len + 1 : 0);
    if (!burst_done) burst_active = 1'b0;
  endtask

  task automatic feed(input int tgt, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      push_word(tgt, $urandom());
    end
  endtask

  task automatic run_burst(input int tgt, input int len, input int pre);
    logic [7:0] addr;
    case (tgt)
      0: addr = 8'h00;
      1: addr = 8'hF0;
      2: addr = 8'h80;
      default: begin
        do addr = 8'($urandom_range(0, 255)); while (addr == 8'h00 || addr == 8'hF0 || addr == 8'h80);
      end
    endcase
    if (tgt < 2) begin
      for (int i = 0; i < pre; i++) push_word(tgt, $urandom());
      fork
        feed(tgt, len + 1 - pre);
        begin issue_ar(addr, len, 4'($urandom_range(0, 15)), tgt, 1'b0); wait_done(tgt, len); end
      join
    end else begin
      issue_ar(addr, len, 4'($urandom_range(0, 15)), tgt, 1'b1);
      wait_done(tgt, len);
    end
  endtask

  initial begin
    int t;
    reset = 1'b1;
    bus.axs_s0_arvalid = 1'b0; bus.axs_s0_arid = '0; bus.axs_s0_araddr = '0;
    bus.axs_s0_arlen = '0; bus.axs_s0_arsize = '0; bus.axs_s0_arburst = '0;
    repeat (3) @(negedge clk);
    check_val("rst_arready", bus.axs_s0_arready, 0);
    check_val("rst_rvalid", bus.axs_s0_rvalid, 0);
    check_val("rst_rlast", bus.axs_s0_rlast, 0);
    check_val("rst_rresp", bus.axs_s0_rresp, 0);
    check_val("rst_rid", bus.axs_s0_rid, 0);
    check_val("rst_rdata", bus.axs_s0_rdata, 0);
    check_val("rst_pops", {bus.varint_out_fifo_pop, bus.raw_data_out_fifo_pop}, 0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_val("idle_arready", bus.axs_s0_arready, 1);

    // Two varint words, full-rate rready.
    rready_pct = 100;
    push_word(0, 32'hA1); push_word(0, 32'hB2);
    repeat (2) @(posedge clk);
    issue_ar(8'h00, 1, 4'd3, 0, 1'b1);
    wait_done(0, 1);

    // Raw read stalls on an empty FIFO before the word arrives.
    issue_ar(8'hF0, 0, 4'd5, 1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check_val("stall_rvalid", bus.axs_s0_rvalid, 0);
      check_val("stall_raw_pop", bus.raw_data_out_fifo_pop, 0);
    end
    push_word(1, 32'hDEADBEEF);
    wait_done(1, 0);

    // Status word with varint empty and raw holding one word.
    push_word(1, $urandom());
    repeat (3) @(posedge clk);
    issue_ar(8'h80, 0, 4'd7, 2, 1'b1);
    wait_done(2, 0);
    check_val("status_value", exp_status, 32'h1);

    // Unmapped address returns four SLVERR beats.
    issue_ar(8'h44, 3, 4'd9, 3, 1'b1);
    wait_done(3, 3);

    // rready held low across the first beat of three.
    for (int i = 0; i < 3; i++) push_word(0, $urandom());
    rready_low = 1'b1;
    issue_ar(8'h00, 2, 4'd2, 0, 1'b0);
    t = 0;
    while (!bus.axs_s0_rvalid && t < 50) begin @(negedge clk); t++; end
    check_val("hold_rvalid_seen", bus.axs_s0_rvalid, 1);
    repeat (4) @(negedge clk);
    rready_low = 1'b0;
    wait_done(0, 2);

    // Longest burst: 256 beats.
    rready_pct = 80;
    run_burst(0, 255, 200);

    for (int it = 0; it < 40; it++) begin
      int tgt, len;
      tgt = $urandom_range(0, 3);
      len = $urandom_range(0, 7);
      rready_pct = $urandom_range(30, 100);
      if (tgt == 2) begin
        if ($urandom_range(0, 1) == 1) push_word(0, $urandom());
        if ($urandom_range(0, 1) == 1) push_word(1, $urandom());
        repeat (3) @(posedge clk);
      end
      run_burst(tgt, len, $urandom_range(0, len + 1));
    end

    // Reset during beat 2 of 8; the burst is abandoned and a new one is served.
    rready_pct = 100;
    for (int i = 0; i < 8; i++) push_word(0, $urandom());
    issue_ar(8'h00, 7, 4'd6, 0, 1'b0);
    t = 0;
    while (beat_idx < 1 && t < 100) begin @(negedge clk); t++; end
    check_val("mid_beat_reached", beat_idx >= 1, 1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    burst_active = 1'b0;
    check_val("mid_rst_arready", bus.axs_s0_arready, 0);
    check_val("mid_rst_rvalid", bus.axs_s0_rvalid, 0);
    check_val("mid_rst_rlast", bus.axs_s0_rlast, 0);
    check_val("mid_rst_rdata", bus.axs_s0_rdata, 0);
    check_val("mid_rst_rid", bus.axs_s0_rid, 0);
    check_val("mid_rst_pops", {bus.varint_out_fifo_pop, bus.raw_data_out_fifo_pop}, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    v_exp = v_fifo;
    r_exp = r_fifo;
    check_val("post_rst_pops", {bus.varint_out_fifo_pop, bus.raw_data_out_fifo_pop}, 0);
    run_burst(0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
